if_fetch: RTL and testbench



---
 rtl/if_fetch_if.sv | 21 ++
 rtl/if_fetch.sv | 124 ++++++++++++
 tb/tb_if_fetch.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction bus req/ack handshake between fetch stage and memory
interface if_fetch_if;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_data_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_ack_i,
        input  ibus_data_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_ack_i,
        output ibus_data_i
    );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - MIPS IF stage: PC owner, variable-latency ibus fetch, delay-slot branch handling
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] PC_STEP  = 32'h00000004
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              branch_flag_i,
    input  logic [31:0]       branch_target_address_i,
    if_fetch_if.master        ibus,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst,
    output logic              stallreq_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst_buf;
    logic        pend_valid;
    logic [31:0] pend_target;

    logic        handoff;
    logic [31:0] next_pc;

    // Only hold-PC and hold-ID bits of the ctrl vector matter to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5:3], stall[1]};

    // A handoff is the cycle an instruction is accepted by IF/ID; it is the delay slot
    // of any branch that resolved while it was in flight.
    always_comb begin
        handoff = 1'b0;
        case (state)
            FETCH:   handoff = ibus.ibus_ack_i && !stall[0];
            VALID:   handoff = !stall[0];
            default: handoff = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = pc + PC_STEP;
        if (branch_flag_i) begin
            next_pc = branch_target_address_i;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inst_buf    <= 32'h0;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (ibus.ibus_ack_i) begin
                        if (!stall[0]) begin
                            pc <= next_pc;
                        end else begin
                            inst_buf <= ibus.ibus_data_i;
                            state    <= VALID;
                        end
                    end
                end
                VALID: begin
                    if (!stall[0]) begin
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A branch seen outside a handoff is remembered until the delay slot is taken.
            if (handoff) begin
                pend_valid <= 1'b0;
            end else if (branch_flag_i && !stall[2]) begin
                pend_valid  <= 1'b1;
                pend_target <= branch_target_address_i;
            end
        end
    end

    always_comb begin
        ibus.ibus_req_o  = 1'b0;
        ibus.ibus_addr_o = 32'h0;
        if_pc            = 32'h0;
        if_inst          = 32'h0;
        stallreq_if      = 1'b0;
        case (state)
            FETCH: begin
                ibus.ibus_req_o  = 1'b1;
                ibus.ibus_addr_o = pc;
                if_pc            = pc;
                if_inst          = ibus.ibus_ack_i ? ibus.ibus_data_i : 32'h0;
                stallreq_if      = !ibus.ibus_ack_i;
            end
            VALID: begin
                ibus.ibus_addr_o = pc;
                if_pc            = pc;
                if_inst          = inst_buf;
            end
            default: begin
                ibus.ibus_req_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed vector bench for if_fetch
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    if_fetch_if ibus ();

    // Memory model: every word holds its own address.
    assign ibus.ibus_data_i = ibus.ibus_addr_o;

    if_fetch dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .ibus                    (ibus.master),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .stallreq_if             (stallreq_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        s0;
        logic        s2;
        logic        ack;
        logic        br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic [31:0] inst;
        logic        sreq;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic r, input logic s0, input logic s2, input logic ack,
                                input logic br, input logic [31:0] tgt, input logic req,
                                input logic [31:0] addr, input logic [31:0] inst, input logic sreq);
        vec_t v;
        v.rst = r; v.s0 = s0; v.s2 = s2; v.ack = ack; v.br = br; v.tgt = tgt;
        v.req = req; v.addr = addr; v.inst = inst; v.sreq = sreq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s0, input logic s2, input logic ack,
                         input logic br, input logic [31:0] tgt);
        rst                     = r;
        stall                   = {3'b000, s2, 1'b0, s0};
        ibus.ibus_ack_i         = ack;
        branch_flag_i           = br;
        branch_target_address_i = tgt;
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                              input logic [31:0] inst, input logic sreq);
        check({tag, ".req"},      {31'b0, ibus.ibus_req_o}, {31'b0, req});
        check({tag, ".addr"},     ibus.ibus_addr_o, addr);
        check({tag, ".if_pc"},    if_pc, addr);
        check({tag, ".if_inst"},  if_inst, inst);
        check({tag, ".stallreq"}, {31'b0, stallreq_if}, {31'b0, sreq});
    endtask

    initial begin
        //               rst s0 s2 ack br tgt            req addr          inst          sreq
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,          0, 32'h0,        32'h0,        0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 32'h0,          0, 32'h0,        32'h0,        0);
        vecs[2]  = mk(0, 0, 0, 1, 0, 32'h0,          1, 32'h0,        32'h0,        0);
        vecs[3]  = mk(0, 0, 0, 1, 0, 32'h0,          1, 32'h4,        32'h4,        0);
        vecs[4]  = mk(0, 0, 0, 1, 0, 32'h0,          1, 32'h8,        32'h8,        0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,          1, 32'hC,        32'h0,        1);
        vecs[6]  = mk(0, 0, 0, 0, 0, 32'h0,          1, 32'hC,        32'h0,        1);
        vecs[7]  = mk(0, 0, 0, 1, 0, 32'h0,          1, 32'hC,        32'hC,        0);
        vecs[8]  = mk(0, 1, 0, 1, 0, 32'h0,          1, 32'h10,       32'h10,       0);
        vecs[9]  = mk(0, 1, 0, 1, 0, 32'h0,          0, 32'h10,       32'h10,       0);
        vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,          0, 32'h10,       32'h10,       0);
        vecs[11] = mk(0, 0, 0, 1, 1, 32'h100,        1, 32'h14,       32'h14,       0);
        vecs[12] = mk(0, 0, 0, 1, 0, 32'h0,          1, 32'h100,      32'h100,      0);
        vecs[13] = mk(0, 0, 0, 0, 1, 32'h200,        1, 32'h104,      32'h0,        1);
        vecs[14] = mk(0, 0, 0, 1, 0, 32'h0,          1, 32'h104,      32'h104,      0);
        vecs[15] = mk(0, 0, 0, 1, 0, 32'h0,          1, 32'h200,      32'h200,      0);
        vecs[16] = mk(0, 0, 1, 0, 1, 32'h300,        1, 32'h204,      32'h0,        1);
        vecs[17] = mk(0, 0, 0, 1, 0, 32'h0,          1, 32'h204,      32'h204,      0);
        vecs[18] = mk(0, 0, 0, 0, 1, 32'h400,        1, 32'h208,      32'h0,        1);
        vecs[19] = mk(0, 0, 0, 0, 1, 32'h500,        1, 32'h208,      32'h0,        1);
        vecs[20] = mk(0, 0, 0, 1, 0, 32'h0,          1, 32'h208,      32'h208,      0);
        vecs[21] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h500,      32'h0,        1);
        vecs[22] = mk(0, 0, 0, 1, 0, 32'h0,          0, 32'h0,        32'h0,        0);
        vecs[23] = mk(0, 0, 0, 1, 0, 32'h0,          1, 32'h0,        32'h0,        0);
        vecs[24] = mk(0, 0, 0, 1, 1, 32'hFFFFFFFC,   1, 32'h4,        32'h4,        0);
        vecs[25] = mk(0, 0, 0, 1, 0, 32'h0,          1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0);
        vecs[26] = mk(0, 0, 0, 0, 0, 32'h0,          1, 32'h0,        32'h0,        1);

        drive(1, 0, 0, 0, 0, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].s0, vecs[i].s2, vecs[i].ack, vecs[i].br, vecs[i].tgt);
            @(negedge clk);
            check_outs($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].inst, vecs[i].sreq);
            @(posedge clk);
            #1;
        end

        // Branch resolving while the delay slot sits in VALID under a hold-PC stall.
        drive(0, 0, 0, 1, 0, 32'h0);
        @(negedge clk);
        check_outs("h0", 1'b1, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1, 0, 1, 0, 32'h0);
        @(negedge clk);
        check_outs("h1", 1'b1, 32'h4, 32'h4, 1'b0);
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 1, 32'h600);
        @(negedge clk);
        check_outs("h2", 1'b0, 32'h4, 32'h4, 1'b0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check_outs("h3", 1'b0, 32'h4, 32'h4, 1'b0);
        @(posedge clk); #1;
        begin
            int waited;
            waited = 0;
            @(negedge clk);
            while (!ibus.ibus_req_o && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            check("h4.req_seen", {31'b0, ibus.ibus_req_o}, 32'h1);
            check("h4.addr", ibus.ibus_addr_o, 32'h600);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
